reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Per-register pending-write scoreboard that decides when the instruction held in ID may issue into EX. It tracks in-flight "late" writers (load, mul/div, csr-read results that cannot be forwarded from EX) with a saturating counter per GPR. It raises a stall while any source of the ID instruction is still pending. It sits between the decode stage and the forwarding network: the forwarding network supplies values, and this block only sequences issue.

## Interface
- NREG, 32, number of architectural GPRs; r0 is never tracked
- CNT_W, 2, counter width; max outstanding late writers per register = 2^CNT_W-1
- clk  in  1  core clock
- reset  in  1  synchronous, active-high; clears all state
- id_valid  in  1  ID holds a valid instruction
- id_raddr1, id_raddr2  in  5  source register numbers
- id_rf_we  in  1  instruction writes a GPR
- id_rf_waddr  in  5  destination register
- id_late  in  1  result is produced late and must be tracked
- id_serial  in  1  instruction may only issue with an empty scoreboard
- ex_allowin  in  1  EX can accept an instruction this cycle
- rel_valid  in  1  a tracked late result became forwardable or was written back
- rel_waddr  in  5  register of the released result
- flush  in  1  exception/ertn flush; all younger in-flight work is cancelled
- stall  out  1  ID must hold its instruction
- issue_go  out  1  instruction transfers ID->EX at this edge
- busy  out  1  any counter nonzero
- pending  out  NREG  bit i = counter[i] != 0; bit 0 is always 0
- err_underflow  out  1  sticky; set on a release to a zero counter

## Operation
- Counters cnt[1..NREG-1] each hold an unsigned CNT_W-bit value, 0 at reset. cnt[0] is tied to 0.
- Hazard: raw1 = (id_raddr1!=0) & pending[id_raddr1]; raw2 likewise for id_raddr2.
- Overflow guard: ovf = id_rf_we & id_late & (id_rf_waddr!=0) & (cnt[id_rf_waddr]==max).
- Serialize: ser = id_serial & busy.
- stall = id_valid & (raw1 | raw2 | ovf | ser) & ~flush.
- issue_go = id_valid & ex_allowin & ~stall & ~flush.
- inc = issue_go & id_rf_we & id_late & (id_rf_waddr!=0).
- dec = rel_valid & (rel_waddr!=0) & (cnt[rel_waddr]!=0).
- Per-register update:
  - inc only: +1.
  - dec only: -1.
  - Both on the same register: unchanged.
  - Both on different registers: each applied independently.
- rel_valid to a zero counter: the counter stays 0 and err_underflow is set until reset.
- flush: all counters go to 0 at the edge. It overrides inc and dec in the same cycle. err_underflow is not cleared by flush.
- Non-late writers (id_late=0) never touch counters; the forwarding network covers them.
- id_valid=0: stall=0, issue_go=0, regardless of other inputs.

## Timing
- stall, issue_go, busy and pending are combinational from registered counters and current inputs; no added issue latency.
- Counter updates take effect at the next clk edge:
  - A release at cycle t clears the stall at t+1, not at t (no same-cycle release bypass).
  - An instruction issued at cycle t writing rX makes pending[rX]=1 at t+1.
  - A dependent instruction in ID at t+1 stalls.
- Reset values:
  - All counters = 0.
  - stall = 0, issue_go = 0 (given id_valid=0), busy = 0, pending = 0, err_underflow = 0.
- Reset during outstanding writers discards them; any later releases are the caller's error and set err_underflow.
- Saturation: the counter never wraps. An issue that would exceed max stalls until a release.

## Structure
- Shared package/macro header holds NREG, CNT_W, the register address width (5) and CNT_MAX.
- One natural sub-module: sb_counter, a single saturating up/down counter with inc, dec and clr inputs and a nonzero output. It is instantiated NREG-1 times; the top level holds the decode, hazard and issue logic.

## Test plan
- Load r5 issues (late, we), next instruction reads r5 → stall=1 until rel_valid/rel_waddr=5. Stall drops the cycle after the release, and issue_go=1 if ex_allowin=1.
- Three late writes to r7 issue back to back (CNT_W=2), fourth late write to r7 in ID → stall=1 (ovf). One release → cnt[7]=2 and the fourth issues the next cycle.
- Same cycle: issue late write to r9 and release r9 with cnt[9]=1 → cnt[9] stays 1 and pending[9]=1.
- r4, r6 pending, flush=1 together with a valid issuing late write → issue_go=0, pending=0 and busy=0 next cycle.
- Read of r0 while a late write targets r0 → no stall, pending[0]=0. A release to r3 with cnt[3]=0 → err_underflow=1 and stays 1 through flush.
- id_serial=1 with r2 pending → stall until release of r2; the instruction issues at the cycle after busy falls to 0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared parameters for the register pending-write scoreboard.
//   NREG    : number of architectural GPRs (r0 is never tracked)
//   CNT_W   : width of each per-register outstanding-writer counter
//   AW      : register address width
//   CNT_MAX : largest value a counter may hold (saturation point)
package reg_scoreboard_pkg;

  localparam int NREG  = 32;
  localparam int CNT_W = 2;
  localparam int AW    = 5;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one saturating up/down counter of outstanding late writers
// for a single GPR.
// Ports:
//   clk, reset : core clock, synchronous active-high reset
//   inc_i      : one more late writer issued to this register
//   dec_i      : one late writer released (forwardable or written back)
//   clr_i      : flush, drops all outstanding writers; beats inc/dec
//   cnt_o      : current count
//   nz_o       : count is nonzero (register pending)
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nz_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // inc and dec together cancel; both ends saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-GPR pending late-write tracker that decides when the
// instruction in ID may issue into EX.
// Ports:
//   clk, reset      : core clock, synchronous active-high reset
//   id_valid        : ID holds a valid instruction
//   id_raddr1/2     : source registers of the ID instruction
//   id_rf_we        : ID instruction writes a GPR
//   id_rf_waddr     : its destination register
//   id_late         : its result is produced late and must be tracked
//   id_serial       : it may only issue with an empty scoreboard
//   ex_allowin      : EX accepts an instruction this cycle
//   rel_valid/waddr : a tracked late result was released for this register
//   flush           : cancel all in-flight work, clear every counter
//   stall           : ID must hold its instruction
//   issue_go        : instruction moves ID->EX at this edge
//   busy            : some register has an outstanding late writer
//   pending         : per-register outstanding flag (bit 0 always 0)
//   err_underflow   : sticky, release seen for a register with no writer
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_raddr1,
  input  logic [AW-1:0]   id_raddr2,
  input  logic            id_rf_we,
  input  logic [AW-1:0]   id_rf_waddr,
  input  logic            id_late,
  input  logic            id_serial,
  input  logic            ex_allowin,
  input  logic            rel_valid,
  input  logic [AW-1:0]   rel_waddr,
  input  logic            flush,
  output logic            stall,
  output logic            issue_go,
  output logic            busy,
  output logic [NREG-1:0] pending,
  output logic            err_underflow
);

  logic [CNT_W-1:0] cnt [NREG];

  logic raw1, raw2, wr_late, ovf, ser;
  logic inc, dec, rel_zero;
  logic err_q, err_d;

  assign cnt[0]     = '0;
  assign pending[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (inc && (id_rf_waddr == AW'(i))),
      .dec_i (dec && (rel_waddr == AW'(i))),
      .clr_i (flush),
      .cnt_o (cnt[i]),
      .nz_o  (pending[i])
    );
  end

  assign busy = |pending;

  assign raw1    = (id_raddr1 != '0) && pending[id_raddr1];
  assign raw2    = (id_raddr2 != '0) && pending[id_raddr2];
  assign wr_late = id_rf_we && id_late && (id_rf_waddr != '0);
  // Issuing one more late writer to a saturated register would lose track.
  assign ovf     = wr_late && (cnt[id_rf_waddr] == CNT_MAX);
  assign ser     = id_serial && busy;

  assign stall    = id_valid && (raw1 || raw2 || ovf || ser) && !flush;
  assign issue_go = id_valid && ex_allowin && !stall && !flush;

  assign inc      = issue_go && wr_late;
  assign dec      = rel_valid && (rel_waddr != '0) && (cnt[rel_waddr] != '0);
  assign rel_zero = rel_valid && (rel_waddr != '0) && (cnt[rel_waddr] == '0);

  // Only reset clears the error; flush deliberately leaves it set.
  assign err_d = err_q || rel_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_raddr1, id_raddr2;
  logic        id_rf_we;
  logic [4:0]  id_rf_waddr;
  logic        id_late, id_serial, ex_allowin;
  logic        rel_valid;
  logic [4:0]  rel_waddr;
  logic        flush;
  logic        stall, issue_go, busy, err_underflow;
  logic [31:0] pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_raddr1     (id_raddr1),
    .id_raddr2     (id_raddr2),
    .id_rf_we      (id_rf_we),
    .id_rf_waddr   (id_rf_waddr),
    .id_late       (id_late),
    .id_serial     (id_serial),
    .ex_allowin    (ex_allowin),
    .rel_valid     (rel_valid),
    .rel_waddr     (rel_waddr),
    .flush         (flush),
    .stall         (stall),
    .issue_go      (issue_go),
    .busy          (busy),
    .pending       (pending),
    .err_underflow (err_underflow)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  ra1, ra2;
    logic        we;
    logic [4:0]  wa;
    logic        late, serial, allowin, relv;
    logic [4:0]  rela;
    logic        flush;
    logic        e_stall, e_go, e_busy;
    logic [31:0] e_pend;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] b(input int n);
    logic [31:0] one;
    one = 32'd1;
    return one << n;
  endfunction

  function automatic vec_t mk(
    input logic valid, input logic [4:0] ra1, input logic [4:0] ra2,
    input logic we, input logic [4:0] wa, input logic late,
    input logic serial, input logic allowin, input logic relv,
    input logic [4:0] rela, input logic fl,
    input logic e_stall, input logic e_go, input logic e_busy,
    input logic [31:0] e_pend, input logic e_err);
    vec_t v;
    v.valid = valid; v.ra1 = ra1; v.ra2 = ra2; v.we = we; v.wa = wa;
    v.late = late; v.serial = serial; v.allowin = allowin; v.relv = relv;
    v.rela = rela; v.flush = fl; v.e_stall = e_stall; v.e_go = e_go;
    v.e_busy = e_busy; v.e_pend = e_pend; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_raddr1 = v.ra1; id_raddr2 = v.ra2;
    id_rf_we = v.we; id_rf_waddr = v.wa; id_late = v.late;
    id_serial = v.serial; ex_allowin = v.allowin;
    rel_valid = v.relv; rel_waddr = v.rela; flush = v.flush;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("stall", idx, {31'd0, stall}, {31'd0, v.e_stall});
    chk("issue_go", idx, {31'd0, issue_go}, {31'd0, v.e_go});
    chk("busy", idx, {31'd0, busy}, {31'd0, v.e_busy});
    chk("pending", idx, pending, v.e_pend);
    chk("err_underflow", idx, {31'd0, err_underflow}, {31'd0, v.e_err});
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    // valid, ra1, ra2, we, wa, late, ser, alw, relv, rela, flush | stall go busy pend err
    vecs.push_back(mk(0,5,5,1,5,1,1,1,0,0,0, 0,0,0,0,0));      // idle ID ignores junk
    // load to r5, dependent read, release, issue
    vecs.push_back(mk(1,0,0,1,5,1,0,1,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(1,5,0,0,0,0,0,1,0,0,0, 1,0,1,b(5),0));
    vecs.push_back(mk(1,0,5,0,0,0,0,1,1,5,0, 1,0,1,b(5),0));   // no same-cycle bypass
    vecs.push_back(mk(1,0,5,0,0,0,0,1,0,0,0, 0,1,0,0,0));
    // saturate r7
    vecs.push_back(mk(1,0,0,1,7,1,0,1,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,7,1,0,1,0,0,0, 0,1,1,b(7),0));
    vecs.push_back(mk(1,0,0,1,7,1,0,1,0,0,0, 0,1,1,b(7),0));
    vecs.push_back(mk(1,0,0,1,7,1,0,1,0,0,0, 1,0,1,b(7),0));   // cnt=3 ovf
    vecs.push_back(mk(1,0,0,1,7,1,0,1,1,7,0, 1,0,1,b(7),0));
    vecs.push_back(mk(1,0,0,1,7,1,0,1,0,0,0, 0,1,1,b(7),0));   // cnt=2, issues
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7,0, 0,0,1,b(7),0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7,0, 0,0,1,b(7),0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7,0, 0,0,1,b(7),0));
    // same-cycle inc and dec on r9
    vecs.push_back(mk(1,0,0,1,9,1,0,1,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,9,1,0,1,1,9,0, 0,1,1,b(9),0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,9,0, 0,0,1,b(9),0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    // r4, r6 pending then flush with a hazarding late write in ID
    vecs.push_back(mk(1,0,0,1,4,1,0,1,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,6,1,0,1,0,0,0, 0,1,1,b(4),0));
    vecs.push_back(mk(1,4,0,1,10,1,0,1,0,0,1, 0,0,1,b(4)|b(6),0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    // r0 never tracked
    vecs.push_back(mk(1,0,0,1,0,1,0,1,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 0,1,0,0,0));
    // underflow on r3, sticky through flush
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,3,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1));
    // serial instruction waits for empty scoreboard
    vecs.push_back(mk(1,0,0,1,2,1,0,1,0,0,0, 0,1,0,0,1));
    vecs.push_back(mk(1,1,0,0,0,0,1,1,0,0,0, 1,0,1,b(2),1));
    vecs.push_back(mk(1,1,0,0,0,0,1,1,1,2,0, 1,0,1,b(2),1));
    vecs.push_back(mk(1,1,0,0,0,0,1,1,0,0,0, 0,1,0,0,1));
    // EX not accepting
    vecs.push_back(mk(1,3,3,0,0,0,0,0,0,0,0, 0,0,0,0,1));

    reset = 1'b1;
    drive(idle);
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset_pending", -1, pending, 32'd0);
    chk("reset_busy", -1, {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      chk_all(i, vecs[i]);
      @(negedge clk);
    end

    // reset with an outstanding writer discards it; a later release underflows
    drive(mk(1,0,0,1,12,1,0,1,0,0,0, 0,1,0,0,0));
    #2;
    chk("rst_seq_issue", 100, {31'd0, issue_go}, 32'd1);
    @(negedge clk);
    drive(idle);
    reset = 1'b1;
    #2;
    chk("rst_seq_pend_before", 101, pending, b(12));
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_seq_pend_after", 102, pending, 32'd0);
    chk("rst_seq_err_cleared", 102, {31'd0, err_underflow}, 32'd0);
    @(negedge clk);
    rel_valid = 1'b1;
    rel_waddr = 5'd12;
    @(negedge clk);
    drive(idle);
    #2;
    chk("rst_seq_err_set", 103, {31'd0, err_underflow}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
